// File: rtl/sap1_program_loader.sv
// Host-side SAP-1 programmer: streams 16 bytes into RAM, releases clear, waits
// for halt (or timeout) and captures the display register.
module sap1_program_loader #(
  parameter int WE_CYCLES      = 2,
  parameter int CLR_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       restart,
  input  logic       HLT_bar,
  input  logic [7:0] display,
  output logic [3:0] programmer_address,
  output logic [7:0] programmer_data,
  output logic       read_or_write,
  output logic       run_or_prog,
  output logic       sap_clr,
  output logic       sap_clr_bar,
  output logic [7:0] result,
  output logic       done,
  output logic       timeout
);

  localparam int PH_MAX = (WE_CYCLES > CLR_CYCLES) ? WE_CYCLES : CLR_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // LOAD take byte | SETUP/WRITE/HOLD strobe RAM | RUNCLR clear SAP | RUN await halt | DONE
  typedef enum logic [2:0] {
    S_LOAD,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_RUNCLR,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    result_q, result_d;
  logic          timeout_q, timeout_d;
  logic          hs_meta_q, hs_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= S_LOAD;
      addr_q    <= 4'd0;
      data_q    <= 8'hFF;
      ph_q      <= '0;
      tmr_q     <= '0;
      result_q  <= 8'h00;
      timeout_q <= 1'b0;
      hs_meta_q <= 1'b1;
      hs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ph_q      <= ph_d;
      tmr_q     <= tmr_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      hs_meta_q <= HLT_bar;
      hs_q      <= hs_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ph_d      = ph_q;
    tmr_d     = tmr_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          data_d  = ~in_data;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        ph_d    = PW'(WE_CYCLES - 1);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (ph_q == '0) begin
          state_d = S_HOLD;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (addr_q == 4'hF) begin
          ph_d    = PW'(CLR_CYCLES);
          state_d = S_RUNCLR;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      // sap_clr is high while ph_q counts down, then one low cycle before RUN
      S_RUNCLR: begin
        if (ph_q == '0) begin
          tmr_d   = TW'(TIMEOUT_CYCLES - 1);
          state_d = S_RUN;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_RUN: begin
        if (!hs_q) begin
          result_d  = display;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (tmr_q == '0) begin
          result_d  = display;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DONE: begin
        if (restart) begin
          addr_d    = 4'd0;
          timeout_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign in_ready           = (state_q == S_LOAD) && !CLR;
  assign programmer_address = addr_q;
  assign programmer_data    = data_q;
  assign read_or_write      = (state_q != S_WRITE);
  assign run_or_prog        = (state_q == S_RUNCLR) || (state_q == S_RUN) || (state_q == S_DONE);
  assign sap_clr            = (state_q inside {S_LOAD, S_SETUP, S_WRITE, S_HOLD}) ||
                              ((state_q == S_RUNCLR) && (ph_q != '0));
  assign sap_clr_bar        = !sap_clr;
  assign result             = result_q;
  assign done               = (state_q == S_DONE);
  assign timeout            = timeout_q;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Streams programs into the loader against a RAM/halt stand-in for the SAP-1;
// RAM writes are scored from a queue filled as bytes are accepted.
module tb_sap1_program_loader;
  localparam int WE_CYCLES      = 2;
  localparam int CLR_CYCLES     = 3;
  localparam int TIMEOUT_CYCLES = 1024;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       restart = 1'b0;
  logic       HLT_bar = 1'b1;
  logic [7:0] display = 8'h00;
  logic       in_ready, read_or_write, run_or_prog, sap_clr, sap_clr_bar, done, timeout;
  logic [3:0] programmer_address;
  logic [7:0] programmer_data, result;

  sap1_program_loader #(
    .WE_CYCLES(WE_CYCLES), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .HLT_bar(HLT_bar), .display(display),
    .programmer_address(programmer_address), .programmer_data(programmer_data),
    .read_or_write(read_or_write), .run_or_prog(run_or_prog), .sap_clr(sap_clr),
    .sap_clr_bar(sap_clr_bar), .result(result), .done(done), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    int         halt_after;
    bit         rnd;
    bit         gapchk;
    bit         restart_in_run;
    logic [7:0] exp_result;
    logic       exp_timeout;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  wr_t        sbq[$];
  wr_t        e;
  logic [7:0] mem [16];
  logic [7:0] prog [16];
  int         halt_after = 0;
  int         runcnt = 0;
  int         we_len = 0;
  int         nwrites = 0;
  int         hold_cyc = 0;
  int         done_cyc = 0;
  logic       prev_rw = 1'b1;
  logic       prev_rop = 1'b0;
  logic       prev_done = 1'b0;
  vec_t       vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // SAP-1 stand-in and write monitor, sampled just after each rising edge
  always @(posedge CLK) begin
    #1;
    if (sap_clr) begin
      runcnt  = 0;
      HLT_bar = 1'b1;
      display = 8'h00;
    end else if (run_or_prog && HLT_bar) begin
      runcnt++;
      display = runcnt[7:0];
      if (halt_after != 0 && runcnt == halt_after) begin
        HLT_bar = 1'b0;
        display = mem[14] + mem[15];
      end
    end

    chk("clr_bar", sap_clr_bar, !sap_clr);
    if (CLR) begin
      nwrites = 0;
      we_len  = 0;
    end else if (!read_or_write) begin
      if (prev_rw) begin
        nwrites++;
        if (sbq.size() == 0) begin
          chk("write_expected", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", programmer_address, e.addr);
          chk("wr_data", programmer_data, e.data);
        end
        we_len = 1;
      end else begin
        we_len++;
      end
      mem[programmer_address] = ~programmer_data;
    end else if (!prev_rw) begin
      chk("we_len", we_len, WE_CYCLES);
      if (programmer_address == 4'hF) hold_cyc = cyc;
    end
    if (run_or_prog && !prev_rop && !CLR) begin
      chk("rop_rise_nwrites", nwrites, 16);
      chk("rop_rise_after_hold", cyc - hold_cyc, 1);
      nwrites = 0;
    end
    if (done && !prev_done) done_cyc = cyc;
    prev_rw   = read_or_write;
    prev_rop  = run_or_prog;
    prev_done = done;
  end

  task automatic send(input logic [7:0] b, input int idx, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    if (in_ready) begin
      sbq.push_back({idx[3:0], ~b});
      acc_cyc = cyc;
    end
    @(negedge CLK);
  endtask

  task automatic load(input vec_t v);
    int acc, last_acc;
    last_acc = 0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      b = 8'(int'(v.base) + int'(v.step) * k);
      if (v.rnd) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          in_data = 8'($urandom);
          @(negedge CLK);
        end
      end
      prog[k] = b;
      send(b, k, acc);
      if (v.gapchk && k > 0) chk("ready_gap", acc - last_acc, 3 + WE_CYCLES);
      last_acc = acc;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_check(input vec_t v);
    int n;
    n = 0;
    while (!done && n < TIMEOUT_CYCLES + 200) begin
      @(negedge CLK);
      n++;
      if (v.restart_in_run && n == 40) begin
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
        n++;
        chk("restart_in_run_ignored", {done, run_or_prog, sap_clr}, 3'b010);
      end
    end
    chk("done", done, 1);
    chk("timeout", timeout, v.exp_timeout);
    chk("result", result, v.exp_result);
    if (v.exp_timeout) chk("timeout_latency", done_cyc - hold_cyc, CLR_CYCLES + 2 + TIMEOUT_CYCLES);
    for (int k = 0; k < 16; k++) chk("ram", mem[k], prog[k]);
    chk("sb_empty", sbq.size(), 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge CLK);
    chk("done_frozen", {done, in_ready, run_or_prog, result}, {1'b1, 1'b0, 1'b1, v.exp_result});
    in_valid = 1'b0;
    restart  = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    chk("after_restart", {done, timeout, run_or_prog, sap_clr, in_ready, programmer_address},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0});
  endtask

  initial begin
    int acc, n;
    vecs[0] = '{8'h00, 8'h01, 10, 1'b0, 1'b1, 1'b0, 8'h1D, 1'b0};
    vecs[1] = '{8'h10, 8'h03, 50, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0};
    vecs[2] = '{8'hA5, 8'h11, 3,  1'b0, 1'b1, 1'b0, 8'h37, 1'b0};
    vecs[3] = '{8'hC0, 8'h02, 0,  1'b1, 1'b0, 1'b1, 8'h01, 1'b1};

    repeat (3) @(negedge CLK);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rw", read_or_write, 1);
    chk("rst_rop", run_or_prog, 0);
    chk("rst_sap_clr", {sap_clr, sap_clr_bar}, 2'b10);
    chk("rst_addr", programmer_address, 4'h0);
    chk("rst_data", programmer_data, 8'hFF);
    chk("rst_result", result, 8'h00);
    chk("rst_done_timeout", {done, timeout}, 2'b00);
    CLR = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      halt_after = vecs[i].halt_after;
      load(vecs[i]);
      run_check(vecs[i]);
    end

    // abandon byte 7 mid-strobe, then re-stream a full program
    for (int k = 0; k < 8; k++) send(8'(8'h40 + k), k, acc);
    in_valid = 1'b0;
    n = 0;
    while (read_or_write && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("byte7_strobe", {read_or_write, programmer_address}, {1'b0, 4'h7});
    CLR = 1'b1;
    @(negedge CLK);
    chk("clr_mid_write",
        {read_or_write, programmer_address, programmer_data, sap_clr, in_ready, run_or_prog, done},
        {1'b1, 4'h0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    CLR = 1'b0;
    chk("sb_empty_abort", sbq.size(), 0);
    halt_after = vecs[1].halt_after;
    load(vecs[1]);
    run_check(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1);
  end

endmodule
